// File: rtl/enable_seq_pkg.sv
// enable_seq_pkg: shared types and default constants for the enable sequencer.
//   DEF_CNT_W   - default width of delay inputs and internal counters
//   DEF_TMO_CYC - default ack timeout in cycles (ENABLE_SEQ_TIMEOUT_EN builds only)
//   state_e     - sequencer FSM state encoding
package enable_seq_pkg;

    localparam int unsigned DEF_CNT_W   = 8;
    localparam int unsigned DEF_TMO_CYC = 255;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PRE      = 3'd1,
        ST_ACTIVE   = 3'd2,
        ST_WAIT_ACK = 3'd3,
        ST_DONE     = 3'd4
    } state_e;

endpackage

// File: rtl/enable_seq_if.sv
// enable_seq_if: request/enable handshake bundle between a requester and enable_seq.
//   start, pre_dly, hold_dly, ack : requester -> sequencer
//   en_out, busy, done, tmo       : sequencer -> requester / consumer
// Modports: master (requester side), slave (sequencer side).
interface enable_seq_if
    import enable_seq_pkg::*;
#(
    parameter int unsigned CNT_W = DEF_CNT_W
) ();

    logic             start;
    logic [CNT_W-1:0] pre_dly;
    logic [CNT_W-1:0] hold_dly;
    logic             ack;
    logic             en_out;
    logic             busy;
    logic             done;
    logic             tmo;

    modport master (
        output start, pre_dly, hold_dly, ack,
        input  en_out, busy, done, tmo
    );

    modport slave (
        input  start, pre_dly, hold_dly, ack,
        output en_out, busy, done, tmo
    );

endinterface

// File: rtl/enable_seq_dly_cnt.sv
// dly_cnt: loadable down-counter with a registered zero flag; saturates at 0.
//   clk, rst   : clock, synchronous active-high reset (count 0, zero flag 1)
//   load_i     : load load_val_i at the next edge (priority over dec_i)
//   dec_i      : decrement at the next edge unless already zero
//   zero_o     : high while the count is zero
module dly_cnt
    import enable_seq_pkg::*;
#(
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             zero_q;

    // Next count: load wins, otherwise count down and hold at zero (no wrap).
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && !zero_q) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Zero flag is registered from the next count so it always matches cnt_q.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            zero_q <= 1'b1;
        end else begin
            cnt_q  <= cnt_d;
            zero_q <= (cnt_d == '0);
        end
    end

    assign zero_o = zero_q;

endmodule

// File: rtl/enable_seq.sv
// enable_seq: one-shot enable sequencer. On start (in IDLE) it waits pre_dly cycles,
// drives en_out for at least max(hold_dly,1) cycles, waits for ack if not yet seen,
// then pulses done for one cycle and returns to IDLE.
//   clk, rst : clock, synchronous active-high reset
//   bus      : enable_seq_if.slave (start/pre_dly/hold_dly/ack in; en_out/busy/done/tmo out)
// Parameters: CNT_W (counter width), ACTIVE_LOW (en_out polarity), TMO_CYC (ack timeout).
// Macro ENABLE_SEQ_TIMEOUT_EN: adds the WAIT_ACK timeout; without it tmo stays 0.
// All outputs are registered from the current state, so they trail the state by one edge.
module enable_seq
    import enable_seq_pkg::*;
#(
    parameter int unsigned CNT_W      = DEF_CNT_W,
    parameter bit          ACTIVE_LOW = 1'b0,
    parameter int unsigned TMO_CYC    = DEF_TMO_CYC
) (
    input  logic        clk,
    input  logic        rst,
    enable_seq_if.slave bus
);

    // Timeout count must be non-zero and fit the CNT_W-bit counter.
    if ((TMO_CYC == 0) || (((TMO_CYC - 1) >> CNT_W) != 0)) begin : g_bad_tmo
        $error("enable_seq: TMO_CYC does not fit a CNT_W-bit counter");
    end

    state_e           state_q, state_d;
    logic [CNT_W-1:0] hold_q, hold_d;
    logic             ack_seen_q, ack_seen_d;

    logic             cnt_load, cnt_dec, cnt_zero;
    logic [CNT_W-1:0] cnt_val;

    logic             en_q, en_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             tmo_q, tmo_d;

`ifdef ENABLE_SEQ_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TMO_LOAD = CNT_W'(TMO_CYC - 1);

    logic tmo_flag_q, tmo_flag_d;
    logic tmo_load, tmo_dec, tmo_zero;
`endif

    // ACTIVE runs max(h,1) cycles; the counter is loaded with cycles-1.
    function automatic logic [CNT_W-1:0] active_load(input logic [CNT_W-1:0] h);
        return (h == '0) ? '0 : h - CNT_W'(1);
    endfunction

    // PRE and ACTIVE share one counter since they never overlap.
    dly_cnt #(.CNT_W(CNT_W)) u_phase_cnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (cnt_load),
        .load_val_i (cnt_val),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero)
    );

`ifdef ENABLE_SEQ_TIMEOUT_EN
    dly_cnt #(.CNT_W(CNT_W)) u_tmo_cnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (tmo_load),
        .load_val_i (TMO_LOAD),
        .dec_i      (tmo_dec),
        .zero_o     (tmo_zero)
    );
`endif

    // State register and sequence bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            hold_q     <= '0;
            ack_seen_q <= 1'b0;
`ifdef ENABLE_SEQ_TIMEOUT_EN
            tmo_flag_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            ack_seen_q <= ack_seen_d;
`ifdef ENABLE_SEQ_TIMEOUT_EN
            tmo_flag_q <= tmo_flag_d;
`endif
        end
    end

    // Next-state and counter control.
    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        ack_seen_d = ack_seen_q;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;
        cnt_val    = '0;
`ifdef ENABLE_SEQ_TIMEOUT_EN
        tmo_flag_d = tmo_flag_q;
        tmo_load   = 1'b0;
        tmo_dec    = 1'b0;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    hold_d     = bus.hold_dly;
                    ack_seen_d = 1'b0;
`ifdef ENABLE_SEQ_TIMEOUT_EN
                    tmo_flag_d = 1'b0;
`endif
                    cnt_load   = 1'b1;
                    if (bus.pre_dly != '0) begin
                        state_d = ST_PRE;
                        cnt_val = bus.pre_dly - CNT_W'(1);
                    end else begin
                        state_d = ST_ACTIVE;
                        cnt_val = active_load(bus.hold_dly);
                    end
                end
            end
            ST_PRE: begin
                if (cnt_zero) begin
                    state_d  = ST_ACTIVE;
                    cnt_load = 1'b1;
                    cnt_val  = active_load(hold_q);
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (bus.ack) begin
                    ack_seen_d = 1'b1;
                end
                if (cnt_zero) begin
                    // Final ACTIVE cycle: an ack seen earlier or now skips WAIT_ACK.
                    if (ack_seen_q || bus.ack) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_WAIT_ACK;
`ifdef ENABLE_SEQ_TIMEOUT_EN
                        tmo_load = 1'b1;
`endif
                    end
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_WAIT_ACK: begin
                // ack is checked first so a simultaneous timeout resolves as ack.
                if (bus.ack) begin
                    state_d = ST_DONE;
`ifdef ENABLE_SEQ_TIMEOUT_EN
                end else if (tmo_zero) begin
                    state_d    = ST_DONE;
                    tmo_flag_d = 1'b1;
                end else begin
                    tmo_dec = 1'b1;
`endif
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode from the current state.
    always_comb begin
        en_d   = ACTIVE_LOW;
        busy_d = 1'b0;
        done_d = 1'b0;
        tmo_d  = 1'b0;
        unique case (state_q)
            ST_PRE: begin
                busy_d = 1'b1;
            end
            ST_ACTIVE, ST_WAIT_ACK: begin
                busy_d = 1'b1;
                en_d   = !ACTIVE_LOW;
            end
            ST_DONE: begin
                busy_d = 1'b1;
                done_d = 1'b1;
`ifdef ENABLE_SEQ_TIMEOUT_EN
                tmo_d  = tmo_flag_q;
`endif
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            en_q   <= ACTIVE_LOW;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            tmo_q  <= 1'b0;
        end else begin
            en_q   <= en_d;
            busy_q <= busy_d;
            done_q <= done_d;
            tmo_q  <= tmo_d;
        end
    end

    assign bus.en_out = en_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.tmo    = tmo_q;

endmodule

// File: tb/tb_enable_seq.sv
// tb_enable_seq: directed + random stimulus against a timeline model of enable_seq.
// Two DUTs share the stimulus: active-high and active-low en_out.
module tb_enable_seq;

    localparam int unsigned CNT_W = 8;
    localparam int unsigned TMO   = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [CNT_W-1:0] pre;
    logic [CNT_W-1:0] hold;
    logic             ack;

    enable_seq_if #(.CNT_W(CNT_W)) bus0 ();
    enable_seq_if #(.CNT_W(CNT_W)) bus1 ();

    assign bus0.start    = start;
    assign bus0.pre_dly  = pre;
    assign bus0.hold_dly = hold;
    assign bus0.ack      = ack;
    assign bus1.start    = start;
    assign bus1.pre_dly  = pre;
    assign bus1.hold_dly = hold;
    assign bus1.ack      = ack;

    enable_seq #(.CNT_W(CNT_W), .ACTIVE_LOW(1'b0), .TMO_CYC(TMO)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    enable_seq #(.CNT_W(CNT_W), .ACTIVE_LOW(1'b1), .TMO_CYC(TMO)) u_dut_n (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int edge_no = 0;

    // Model: one sequence described by the edge numbers of its milestones.
    bit m_seq;
    int m_n, m_act, m_exp, m_done;
    bit m_acked, m_timed;
    bit x_en, x_busy, x_done, x_tmo;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s @edge %0d: got %0h, expected %0h", tag, edge_no, got, exp);
    endtask

    // Advance the model by one rising edge with the inputs sampled there.
    // m_act: edge entering the enabled phase; m_exp: end of the minimum hold;
    // m_done: edge the sequence completes (-1 while unknown).
    task automatic model_edge(input bit r, input bit s, input int p, input int h, input bit a);
        int e;
        e = edge_no;
        if (r) begin
            m_seq = 1'b0;
        end else begin
            if (m_seq && m_done >= 0 && e >= m_done + 2) m_seq = 1'b0;
            if (!m_seq) begin
                if (s) begin
                    m_seq   = 1'b1;
                    m_n     = e;
                    m_act   = e + p;
                    m_exp   = m_act + ((h == 0) ? 1 : h);
                    m_done  = -1;
                    m_acked = 1'b0;
                    m_timed = 1'b0;
                end
            end else if (m_done < 0) begin
                if (e > m_act && e <= m_exp && a) m_acked = 1'b1;
                if (e == m_exp && m_acked) m_done = e;
                else if (e > m_exp && a) m_done = e;
`ifdef ENABLE_SEQ_TIMEOUT_EN
                else if (e == m_exp + int'(TMO)) begin
                    m_done  = e;
                    m_timed = 1'b1;
                end
`endif
            end
        end
        x_en   = m_seq && (e >= m_act + 1) && (m_done < 0 || e <= m_done);
        x_done = m_seq && (m_done >= 0) && (e == m_done + 1);
        x_tmo  = x_done && m_timed;
        x_busy = m_seq && (e >= m_n + 1) && (m_done < 0 || e <= m_done + 1);
    endtask

    // Drive one cycle of inputs, take the edge, then compare just after it.
    task automatic step(input bit r, input bit s, input int p, input int h, input bit a);
        rst   = r;
        start = s;
        pre   = CNT_W'(p);
        hold  = CNT_W'(h);
        ack   = a;
        @(posedge clk);
        edge_no++;
        model_edge(r, s, p, h, a);
        #1;
        chk("en_out",   bus0.en_out, x_en);
        chk("busy",     bus0.busy,   x_busy);
        chk("done",     bus0.done,   x_done);
        chk("tmo",      bus0.tmo,    x_tmo);
        chk("en_out_n", bus1.en_out, !x_en);
        chk("done_n",   bus1.done,   x_done);
    endtask

    initial begin
        m_seq = 1'b0;
        m_done = -1;
        // Reset state.
        repeat (3) step(1, 0, 0, 0, 0);
        repeat (2) step(0, 0, 0, 0, 0);

        // pre=3, hold=15, ack pulsed inside the enable window.
        step(0, 1, 3, 15, 0);
        repeat (8) step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        repeat (14) step(0, 0, 0, 0, 0);

        // pre=0, hold=0 with ack held: single enabled cycle.
        step(0, 1, 0, 0, 1);
        repeat (5) step(0, 0, 0, 0, 1);

        // pre=2, hold=4, ack withheld then given (or timeout with the macro).
        step(0, 1, 2, 4, 0);
        repeat (18) step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        repeat (4) step(0, 0, 0, 0, 0);

        // Reset mid-enable with a start pulse while busy.
        step(0, 1, 1, 10, 0);
        repeat (4) step(0, 0, 0, 0, 0);
        step(0, 1, 2, 2, 0);
        step(0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 1);
        repeat (3) step(0, 0, 0, 0, 0);

        // start held high: back-to-back acceptance right after DONE.
        repeat (30) step(0, 1, 1, 2, 1);
        repeat (4) step(0, 0, 0, 0, 0);

        // Maximum pre delay, no counter wrap.
        step(0, 1, 255, 1, 1);
        repeat (262) step(0, 0, 0, 0, 1);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 99) == 0),
                 ($urandom_range(0, 3) == 0),
                 int'($urandom_range(0, 6)),
                 int'($urandom_range(0, 6)),
                 ($urandom_range(0, 3) == 0));
        end
        repeat (5) step(0, 0, 0, 0, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
